// File: rtl/sistema_multi_timer_if.sv
// Register-bus interface for sistema_multi_timer: word address, chip select,
// active-low write strobe, 32-bit write data and registered read data.
interface sistema_multi_timer_if #(
  parameter int NUM_CH = 2
) ();
  localparam int AW = $clog2(NUM_CH) + 3;

  logic [AW-1:0] address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/sistema_multi_timer.sv
// sistema_multi_timer: NUM_CH independent down-counting timers behind a
// word-addressed register bus. Each channel owns eight words:
// STATUS, CONTROL, PERIOD, SNAP, COMPARE and three reserved words.
// Optional feature macro SISTEMA_TIMER_PWM_EN enables the COMPARE register
// and the registered per-channel pwm_out; without it COMPARE reads 0 and
// pwm_out is held at 0.
module sistema_multi_timer #(
  parameter int NUM_CH     = 2,
  parameter int CNT_W      = 32,
  parameter int PERIOD_RST = 49999
) (
  input  logic                 clk,
  input  logic                 reset,
  sistema_multi_timer_if.slave bus,
  output logic                 irq,
  output logic [NUM_CH-1:0]    irq_vec,
  output logic [NUM_CH-1:0]    pwm_out
);

  localparam int               AW   = $clog2(NUM_CH) + 3;
  localparam logic [CNT_W-1:0] PRST = CNT_W'(PERIOD_RST);

  logic [31:0] addr_ext;
  logic [28:0] ch;
  logic [2:0]  off;
  logic        wr_en;
  logic [31:0] ch_rd [NUM_CH];
  logic [31:0] rd_mux;
  logic [31:0] readdata_q;

  assign addr_ext = 32'(bus.address);
  assign ch       = addr_ext[31:3];
  assign off      = addr_ext[2:0];
  assign wr_en    = bus.chipselect && !bus.write_n;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d, per_q, per_d, snap_q, snap_d;
    logic             run_q, run_d, to_q, to_d, cont_q, cont_d, ito_q, ito_d;
    logic             zero_q, ld_q, pwm_q, pwm_d;
    logic             wr_sel, wr_st, wr_ct, wr_pe, wr_sn, at_zero, hit;
    logic [31:0]      rd_c;
`ifdef SISTEMA_TIMER_PWM_EN
    logic [CNT_W-1:0] cmp_q, cmp_d;
    logic             wr_cm;

    assign wr_cm = wr_sel && (off == 3'd4);
`endif

    assign wr_sel  = wr_en && (ch == 29'(c));
    assign wr_st   = wr_sel && (off == 3'd0);
    assign wr_ct   = wr_sel && (off == 3'd1);
    assign wr_pe   = wr_sel && (off == 3'd2);
    assign wr_sn   = wr_sel && (off == 3'd3);
    assign at_zero = (cnt_q == '0);
    // Timeout only on the first cycle the counter sits at zero.
    assign hit     = at_zero && !zero_q;

    // Channel next-state: counting, reload, run control and register writes
    always_comb begin
      cnt_d  = cnt_q;
      per_d  = per_q;
      snap_d = snap_q;
      run_d  = run_q;
      to_d   = to_q;
      cont_d = cont_q;
      ito_d  = ito_q;
      pwm_d  = 1'b0;
`ifdef SISTEMA_TIMER_PWM_EN
      cmp_d  = cmp_q;
`endif
      // A PERIOD write takes effect one cycle later and overrides counting.
      if (ld_q) begin
        cnt_d = per_q;
        run_d = 1'b0;
      end else if (run_q) begin
        if (at_zero) begin
          cnt_d = per_q;
          if (!cont_q) run_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      // Software run control applies last so START always wins.
      if (wr_ct) begin
        cont_d = bus.writedata[1];
        ito_d  = bus.writedata[0];
        if (bus.writedata[3]) run_d = 1'b0;
        if (bus.writedata[2]) run_d = 1'b1;
      end
      // A same-cycle timeout beats a clearing STATUS write.
      if (hit)        to_d = 1'b1;
      else if (wr_st) to_d = 1'b0;
      if (wr_pe) per_d  = bus.writedata[CNT_W-1:0];
      if (wr_sn) snap_d = cnt_q;
`ifdef SISTEMA_TIMER_PWM_EN
      if (wr_cm) cmp_d = bus.writedata[CNT_W-1:0];
      pwm_d = run_q && (cnt_q < cmp_q);
`endif
    end

    // Channel state registers
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q  <= PRST;
        per_q  <= PRST;
        snap_q <= '0;
        run_q  <= 1'b0;
        to_q   <= 1'b0;
        cont_q <= 1'b0;
        ito_q  <= 1'b0;
        zero_q <= 1'b0;
        ld_q   <= 1'b0;
        pwm_q  <= 1'b0;
`ifdef SISTEMA_TIMER_PWM_EN
        cmp_q  <= '0;
`endif
      end else begin
        cnt_q  <= cnt_d;
        per_q  <= per_d;
        snap_q <= snap_d;
        run_q  <= run_d;
        to_q   <= to_d;
        cont_q <= cont_d;
        ito_q  <= ito_d;
        zero_q <= at_zero;
        ld_q   <= wr_pe;
        pwm_q  <= pwm_d;
`ifdef SISTEMA_TIMER_PWM_EN
        cmp_q  <= cmp_d;
`endif
      end
    end

    // Channel read view, zero-extended to the bus width
    always_comb begin
      rd_c = '0;
      case (off)
        3'd0: rd_c = {30'd0, run_q, to_q};
        3'd1: rd_c = {30'd0, cont_q, ito_q};
        3'd2: rd_c = 32'(per_q);
        3'd3: rd_c = 32'(snap_q);
`ifdef SISTEMA_TIMER_PWM_EN
        3'd4: rd_c = 32'(cmp_q);
`endif
        default: rd_c = '0;
      endcase
    end

    assign ch_rd[c]   = rd_c;
    assign irq_vec[c] = to_q && ito_q;
    assign pwm_out[c] = pwm_q;
  end

  assign irq = |irq_vec;

  // Select the addressed channel; channel numbers past NUM_CH read 0
  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch == 29'(c)) rd_mux = ch_rd[c];
    end
  end

  // Read data is registered and follows the address whether or not selected
  always_ff @(posedge clk) begin
    if (reset) readdata_q <= '0;
    else       readdata_q <= rd_mux;
  end

  assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_sistema_multi_timer.sv
// Self-checking bench for sistema_multi_timer (NUM_CH=2, CNT_W=16).
// A behavioural model tracks every channel from the register-level rules;
// a compare process checks all outputs each cycle, and directed scenarios
// pin the model with hand-computed values before a long random run.
module tb_sistema_multi_timer;

  localparam logic [15:0] PRST = 16'(49999);

  logic       clk;
  logic       reset;
  logic       irq;
  logic [1:0] irq_vec;
  logic [1:0] pwm_out;

  sistema_multi_timer_if #(.NUM_CH(2)) bus ();

  sistema_multi_timer #(
    .NUM_CH    (2),
    .CNT_W     (16),
    .PERIOD_RST(49999)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .irq    (irq),
    .irq_vec(irq_vec),
    .pwm_out(pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Behavioural model state, one entry per channel.
  logic [15:0] m_cnt [2];
  logic [15:0] m_per [2];
  logic [15:0] m_snap[2];
  logic [15:0] m_cmp [2];
  logic [15:0] m_prev[2];  // counter value seen in the previous cycle
  bit          m_run [2];
  bit          m_to  [2];
  bit          m_cont[2];
  bit          m_ito [2];
  bit          m_ld  [2];  // PERIOD written last cycle, load pending
  bit          m_pwm [2];
  logic [31:0] m_rd;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    int c;
    c = int'(a[3]);
    case (a[2:0])
      3'd0: return {30'd0, m_run[c], m_to[c]};
      3'd1: return {30'd0, m_cont[c], m_ito[c]};
      3'd2: return 32'(m_per[c]);
      3'd3: return 32'(m_snap[c]);
`ifdef SISTEMA_TIMER_PWM_EN
      3'd4: return 32'(m_cmp[c]);
`endif
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model by one clock given the bus inputs sampled at that edge.
  task automatic model_step(input bit rst, input logic [3:0] a, input bit cs,
                            input bit wn, input logic [31:0] wd);
    logic [31:0] rd_next;
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        m_cnt[c] = PRST;  m_per[c] = PRST; m_snap[c] = '0; m_cmp[c] = '0;
        m_prev[c] = 16'd1; m_run[c] = 0;  m_to[c] = 0;     m_cont[c] = 0;
        m_ito[c] = 0;     m_ld[c] = 0;    m_pwm[c] = 0;
      end
      m_rd = '0;
      return;
    end
    rd_next = model_read(a);
    for (int c = 0; c < 2; c++) begin
      bit          wr;
      bit          timeout;
      logic [15:0] cnt;
      logic [15:0] ncnt;
      bit          nrun;
      wr      = cs && !wn && (int'(a[3]) == c);
      cnt     = m_cnt[c];
      timeout = (cnt == 0) && (m_prev[c] != 0);
      ncnt    = cnt;
      nrun    = m_run[c];
      if (m_ld[c]) begin
        ncnt = m_per[c];
        nrun = 0;
      end else if (m_run[c]) begin
        ncnt = (cnt == 0) ? m_per[c] : cnt - 16'd1;
        if (cnt == 0 && !m_cont[c]) nrun = 0;
      end
      m_ld[c] = 0;
      if (wr) begin
        case (a[2:0])
          3'd0: m_to[c] = 0;
          3'd1: begin
            m_cont[c] = wd[1];
            m_ito[c]  = wd[0];
            if (wd[3]) nrun = 0;
            if (wd[2]) nrun = 1;
          end
          3'd2: begin
            m_per[c] = wd[15:0];
            m_ld[c]  = 1;
          end
          3'd3: m_snap[c] = cnt;
`ifdef SISTEMA_TIMER_PWM_EN
          3'd4: m_cmp[c] = wd[15:0];
`endif
          default: ;
        endcase
      end
      if (timeout) m_to[c] = 1;
`ifdef SISTEMA_TIMER_PWM_EN
      m_pwm[c] = m_run[c] && (cnt < m_cmp[c]);
`else
      m_pwm[c] = 0;
`endif
      m_prev[c] = cnt;
      m_cnt[c]  = ncnt;
      m_run[c]  = nrun;
    end
    m_rd = rd_next;
  endtask

  // One bus cycle: drive inputs at the falling edge, update the model at the
  // rising edge, return just after it so directed checks see settled outputs.
  task automatic drive(input bit rst, input logic [3:0] a, input bit cs,
                       input bit wn, input logic [31:0] wd);
    @(negedge clk);
    reset          = rst;
    bus.address    = a;
    bus.chipselect = cs;
    bus.write_n    = wn;
    bus.writedata  = wd;
    @(posedge clk);
    model_step(rst, a, cs, wn, wd);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] wd);
    drive(1'b0, a, 1'b1, 1'b0, wd);
  endtask

  task automatic rd(input logic [3:0] a);
    drive(1'b0, a, 1'b1, 1'b1, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 1'b0, 1'b1, 32'd0);
  endtask

  // Every-cycle comparison of all DUT outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      logic [1:0] e_vec;
      e_vec = {m_to[1] & m_ito[1], m_to[0] & m_ito[0]};
      check("readdata", bus.readdata, m_rd);
      check("irq_vec", 32'(irq_vec), 32'(e_vec));
      check("irq", 32'(irq), 32'(|e_vec));
      check("pwm_out", 32'(pwm_out), {30'd0, m_pwm[1], m_pwm[0]});
    end
  end

  initial begin
    int pwm_hi;
    reset          = 1'b1;
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;

    // Reset with a competing write: reset must win.
    drive(1'b1, 4'd2, 1'b1, 1'b0, 32'd5);
    drive(1'b1, 4'd9, 1'b1, 1'b0, 32'h6);
    chk_en = 1'b1;
    check("rst_readdata", bus.readdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_irq_vec", 32'(irq_vec), 32'd0);
    check("rst_pwm", 32'(pwm_out), 32'd0);
    rd(4'd2);
    check("rst_period_ch0", bus.readdata, 32'd49999);
    rd(4'd9);
    check("rst_control_ch1", bus.readdata, 32'd0);

    // ch1 continuous, period 4: TO appears after 5 counts.
    wr(4'd10, 32'd4);
    wr(4'd9, 32'h6);
    for (int i = 0; i < 5; i++) rd(4'd8);
    check("ch1_status_before_to", bus.readdata, 32'd2);
    rd(4'd8);
    check("ch1_status_after_to", bus.readdata, 32'd3);
    rd(4'd0);
    check("ch0_untouched", bus.readdata, 32'd0);
    wr(4'd9, 32'h8);

    // ch0 one-shot with interrupt enabled.
    wr(4'd2, 32'd3);
    wr(4'd1, 32'h5);
    idle(3);
    check("ch0_irq_early", 32'(irq), 32'd0);
    idle(1);
    check("ch0_irq", 32'(irq), 32'd1);
    check("ch0_irq_vec", 32'(irq_vec), 32'd1);
    rd(4'd0);
    check("ch0_status_oneshot", bus.readdata, 32'd1);
    wr(4'd0, 32'd0);
    check("ch0_irq_cleared", 32'(irq), 32'd0);

    // STATUS write in the same cycle as the timeout: TO survives.
    wr(4'd1, 32'h5);
    idle(3);
    check("ch0_irq_pre_collide", 32'(irq), 32'd0);
    wr(4'd0, 32'd0);
    check("ch0_to_wins", 32'(irq), 32'd1);
    rd(4'd0);
    check("ch0_status_collide", bus.readdata, 32'd1);

    // START|STOP together runs; snapshot of 0x1234.
    wr(4'd2, 32'hABCD_1236);
    wr(4'd1, 32'hC);
    rd(4'd0);
    check("ch0_start_wins", bus.readdata, 32'd3);
    idle(1);
    wr(4'd3, 32'd0);
    rd(4'd3);
    check("ch0_snap", bus.readdata, 32'h0000_1234);
    wr(4'd1, 32'h8);

    // ch1 PWM: period 9, compare 3, continuous.
    wr(4'd10, 32'd9);
    wr(4'd12, 32'd3);
    wr(4'd9, 32'h6);
    rd(4'd12);
`ifdef SISTEMA_TIMER_PWM_EN
    check("ch1_compare_read", bus.readdata, 32'd3);
`else
    check("ch1_compare_read", bus.readdata, 32'd0);
`endif
    idle(3);
    pwm_hi = 0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (pwm_out[1]) pwm_hi++;
    end
`ifdef SISTEMA_TIMER_PWM_EN
    check("ch1_pwm_duty", 32'(pwm_hi), 32'd6);
`else
    check("ch1_pwm_duty", 32'(pwm_hi), 32'd0);
`endif
    wr(4'd9, 32'h8);

    // Reset mid-count on ch0 (counter at 2) with a competing write.
    wr(4'd2, 32'd5);
    wr(4'd1, 32'h5);
    idle(3);
    drive(1'b1, 4'd9, 1'b1, 1'b0, 32'h5);
    check("midrst_readdata", bus.readdata, 32'd0);
    check("midrst_irq", 32'(irq), 32'd0);
    check("midrst_pwm", 32'(pwm_out), 32'd0);
    wr(4'd3, 32'd0);
    rd(4'd3);
    check("midrst_counter", bus.readdata, 32'd49999);
    rd(4'd0);
    check("midrst_status_ch0", bus.readdata, 32'd0);
    rd(4'd8);
    check("midrst_status_ch1", bus.readdata, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      int          r;
      logic [3:0]  a;
      logic [31:0] wd;
      r  = int'($urandom_range(0, 99));
      a  = 4'($urandom_range(0, 15));
      wd = $urandom;
      if (r < 2) begin
        drive(1'b1, a, 1'b1, 1'b0, wd);
      end else if (r < 40) begin
        drive(1'b0, a, 1'($urandom_range(0, 1)), 1'b1, wd);
      end else if (r < 45) begin
        drive(1'b0, a, 1'b0, 1'b0, wd);
      end else begin
        case (a[2:0])
          3'd2:    wd = {wd[31:16], 16'($urandom_range(0, 12))};
          3'd4:    wd = {wd[31:16], 16'($urandom_range(0, 14))};
          default: ;
        endcase
        wr(a, wd);
      end
    end

    idle(2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
